// File: rtl/dds_pkg.sv
// Shared widths and FSM encoding for the DDS sweep controller.
package dds_pkg;

  localparam int KW_DEF = 22;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/dds_pulse_gen.sv
// Sample strobe generator: free-running 0..period-1 counter while enabled,
// one-cycle pulse on the terminal count.
module dds_pulse_gen
  import dds_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_en,
  input  logic          i_clr,
  input  logic [DW-1:0] i_period,
  output logic          o_pulse
);

  logic [DW-1:0] r_cnt;
  logic          w_last;

  // period is guaranteed non-zero by the caller
  assign w_last  = (r_cnt == i_period - DW'(1));
  assign o_pulse = i_en & w_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep controller: steps the DDS frequency word every dwell
// samples from k_start towards k_stop, optionally looping.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int KW = KW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [KW-1:0] k_start,
  input  logic [KW-1:0] k_step,
  input  logic [KW-1:0] k_stop,
  input  logic [DW-1:0] div,
  input  logic [DW-1:0] dwell,
  input  logic          loop,
  input  logic          new_sample_ready,
  output logic [KW-1:0] k,
  output logic          sampling_pulse,
  output logic          busy,
  output logic          done
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [KW-1:0] r_k;
  logic [KW-1:0] r_k_start;
  logic [KW-1:0] r_k_step;
  logic [KW-1:0] r_k_stop;
  logic [DW-1:0] r_div;
  logic [DW-1:0] r_dwell;
  logic          r_loop;
  logic [DW-1:0] r_dwell_cnt;

  logic          w_accept;
  logic          w_ack;
  logic          w_last_smp;
  logic          w_bound;
  logic [KW:0]   w_sum;
  logic          w_in_range;
  logic          w_run;

  assign w_run      = (r_state == ST_RUN);
  assign w_accept   = (r_state == ST_IDLE) & start & ~abort;
  assign w_ack      = w_run & new_sample_ready & ~abort;
  assign w_last_smp = (r_dwell_cnt == r_dwell - DW'(1));
  assign w_bound    = w_ack & w_last_smp;
  // extra bit catches wrap-around of the frequency word
  assign w_sum      = {1'b0, r_k} + {1'b0, r_k_step};
  assign w_in_range = ~w_sum[KW] & (w_sum[KW-1:0] <= r_k_stop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_bound & ~w_in_range & ~r_loop) begin
          w_state_nxt = ST_FINISH;
        end
      end
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_k         <= '0;
      r_k_start   <= '0;
      r_k_step    <= '0;
      r_k_stop    <= '0;
      r_div       <= '0;
      r_dwell     <= '0;
      r_loop      <= 1'b0;
      r_dwell_cnt <= '0;
    end else if (w_accept) begin
      r_k         <= k_start;
      r_k_start   <= k_start;
      r_k_step    <= k_step;
      r_k_stop    <= k_stop;
      r_div       <= (div == '0) ? DW'(1) : div;
      r_dwell     <= (dwell == '0) ? DW'(1) : dwell;
      r_loop      <= loop;
      r_dwell_cnt <= '0;
    end else if (w_ack) begin
      if (w_last_smp) begin
        r_dwell_cnt <= '0;
        if (w_in_range) begin
          r_k <= w_sum[KW-1:0];
        end else if (r_loop) begin
          r_k <= r_k_start;
        end
      end else begin
        r_dwell_cnt <= r_dwell_cnt + DW'(1);
      end
    end
  end

  dds_pulse_gen #(
    .DW(DW)
  ) u_pulse (
    .clk      (clk),
    .reset    (reset),
    .i_en     (w_run & ~abort),
    .i_clr    (w_accept),
    .i_period (r_div),
    .o_pulse  (sampling_pulse)
  );

  assign k    = r_k;
  assign busy = w_run;
  assign done = (r_state == ST_FINISH) & ~abort;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: a sweep-level model predicts every
// strobe (cycle and frequency word) and the done pulse.
module tb_dds_sweep_ctrl;

  localparam int     KW   = 22;
  localparam int     DW   = 16;
  localparam longint KMAX = (64'd1 << KW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [KW-1:0] k_start = '0;
  logic [KW-1:0] k_step = '0;
  logic [KW-1:0] k_stop = '0;
  logic [DW-1:0] div = '0;
  logic [DW-1:0] dwell = '0;
  logic          loop = 1'b0;
  logic          new_sample_ready = 1'b0;
  logic [KW-1:0] k;
  logic          sampling_pulse;
  logic          busy;
  logic          done;

  dds_sweep_ctrl #(.KW(KW), .DW(DW)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .abort            (abort),
    .k_start          (k_start),
    .k_step           (k_step),
    .k_stop           (k_stop),
    .div              (div),
    .dwell            (dwell),
    .loop             (loop),
    .new_sample_ready (new_sample_ready),
    .k                (k),
    .sampling_pulse   (sampling_pulse),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int            cyc;
    bit            dn;
    logic [KW-1:0] k;
  } ev_t;

  ev_t q[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // DDS model: acknowledges each strobe one cycle later
  initial begin : dds_ack
    logic p;
    forever begin
      @(negedge clk);
      p = sampling_pulse;
      @(posedge clk);
      #1;
      new_sample_ready = p;
    end
  end

  always @(negedge clk) begin : monitor
    ev_t e;
    if (!reset && (sampling_pulse || done)) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got pulse=%0b done=%0b k=%0d at cycle %0d, expected none",
                 sampling_pulse, done, k, cyc);
      end else begin
        e = q.pop_front();
        if (e.dn != done || e.dn == sampling_pulse ||
            e.cyc != cyc || e.k != k) begin
          n_fail++;
          $display("FAIL event: got done=%0b pulse=%0b k=%0d cycle=%0d, expected done=%0b k=%0d cycle=%0d",
                   done, sampling_pulse, k, cyc, e.dn, e.k, e.cyc);
        end
      end
    end
  end

  task automatic run_sweep(input logic [KW-1:0] ks, input logic [KW-1:0] st,
                           input logic [KW-1:0] sp, input logic [DW-1:0] dv,
                           input logic [DW-1:0] dw, input bit lp,
                           input int stop_rel, input bit stop_rst,
                           input bit poke);
    longint seq[$];
    longint nx;
    int     d, w, c0, nsmp, fin, pb, end_c, n, idx;
    bit     endless, has_stop, fin_ok;
    ev_t    e;

    // frequency words visited by one pass of the sweep
    seq.push_back(longint'(ks));
    if (st != 0) begin
      while (seq.size() < 64) begin
        nx = seq[$] + longint'(st);
        if (nx > longint'(sp) || nx > KMAX) break;
        seq.push_back(nx);
      end
    end
    d        = (dv == 0) ? 1 : int'(dv);
    w        = (dw == 0) ? 1 : int'(dw);
    endless  = !lp && (st == 0) && (ks <= sp);
    has_stop = stop_rel > 0;
    fin_ok   = !lp && !endless;

    @(posedge clk);
    #1;
    k_start = ks; k_step = st; k_stop = sp;
    div = dv; dwell = dw; loop = lp;
    start = 1'b1;
    c0 = cyc;

    nsmp = seq.size() * w;
    fin  = c0 + nsmp * d + 2;
    pb   = has_stop ? c0 + stop_rel : fin;
    if (fin_ok && fin < pb) pb = fin;
    for (int j = 1; c0 + j * d < pb; j++) begin
      n   = (d >= 2) ? j - 1 : ((j >= 2) ? j - 2 : 0);
      idx = n / w;
      if (!fin_ok) idx = idx % seq.size();
      e.cyc = c0 + j * d;
      e.dn  = 1'b0;
      e.k   = KW'(seq[idx]);
      q.push_back(e);
    end
    if (fin_ok && (!has_stop || fin < c0 + stop_rel)) begin
      e.cyc = fin;
      e.dn  = 1'b1;
      e.k   = KW'(seq[$]);
      q.push_back(e);
    end

    @(posedge clk);
    #1;
    start   = 1'b0;
    k_start = KW'($urandom);
    k_step  = KW'($urandom);
    k_stop  = KW'($urandom);
    div     = DW'($urandom);
    dwell   = DW'($urandom);
    loop    = ~lp;
    @(negedge clk);
    chk("busy_in_run", 64'(busy), 64'd1);

    end_c = has_stop ? c0 + stop_rel : fin;
    while (cyc < end_c) begin
      @(posedge clk);
      #1;
      start = poke && (cyc == c0 + 3);
    end
    start = 1'b0;

    if (has_stop && stop_rst) begin
      #2;
      reset = 1'b1;
      #1;
      chk("rst_k", 64'(k), 64'd0);
      chk("rst_pulse", 64'(sampling_pulse), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
    end else if (has_stop) begin
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      @(negedge clk);
      chk("busy_after_abort", 64'(busy), 64'd0);
    end else begin
      @(posedge clk);
      #1;
      chk("busy_after_done", 64'(busy), 64'd0);
      chk("k_held_after_done", 64'(k), 64'(seq[$]));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("events_left", 64'(q.size()), 64'd0);
    q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end, expected end");
    $fatal(1);
  end

  initial begin : stim
    logic [KW-1:0] ks, st, sp;
    logic [DW-1:0] dv, dw;
    longint        lsp;
    bit            lp, endless, srst;
    int            srel, ns;

    #12;
    chk("reset_k", 64'(k), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_pulse", 64'(sampling_pulse), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    run_sweep(100, 50, 200, 4, 2, 0, 0, 0, 0);
    run_sweep(100, 50, 200, 4, 2, 1, 60, 0, 0);
    run_sweep(10, 3, 30, 0, 0, 0, 0, 0, 0);
    run_sweep(22'h3FFFF0, 22'h20, 22'h3FFFFF, 3, 2, 0, 0, 0, 0);
    run_sweep(100, 50, 200, 4, 2, 0, 7, 0, 0);
    run_sweep(100, 50, 200, 4, 2, 0, 0, 0, 1);
    run_sweep(500, 10, 400, 2, 3, 0, 0, 0, 0);
    run_sweep(7, 0, 9, 1, 1, 0, 25, 0, 0);
    run_sweep(100, 50, 200, 4, 2, 0, 13, 1, 1);

    // start together with abort in IDLE must not launch a sweep
    @(posedge clk);
    #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("start_abort_idle", 64'(busy), 64'd0);
    repeat (6) @(posedge clk);

    for (int i = 0; i < 24; i++) begin
      ks = KW'($urandom);
      ns = $urandom_range(0, 9);
      st = (ns == 0) ? '0 :
           (ns == 1) ? KW'($urandom) : KW'($urandom_range(1, 5000));
      ns  = $urandom_range(0, 4);
      lsp = longint'(ks) + longint'(st) * ns;
      if (st > 1) lsp += $urandom_range(0, int'(st) - 1);
      if (lsp > KMAX) lsp = KMAX;
      if ($urandom_range(0, 7) == 0 && ks > 0) lsp = longint'(ks) - 1;
      sp = KW'(lsp);
      dv = DW'($urandom_range(0, 6));
      dw = DW'($urandom_range(0, 3));
      lp = ($urandom_range(0, 3) == 0);
      endless = !lp && (st == 0) && (ks <= sp);
      srel = (lp || endless || $urandom_range(0, 4) == 0) ?
             $urandom_range(5, 60) : 0;
      srst = (srel > 0) && ($urandom_range(0, 3) == 0);
      run_sweep(ks, st, sp, dv, dw, lp, srel, srst, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 Parameter KW, default 22, frequency-word width (matches DDS phase accumulator).
REQ-002 Parameter DW, default 16, width of divider and dwell counters.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a sweep; sampled only in IDLE.
REQ-006 abort  input  1  stop sweep immediately; priority over every other input except reset.
REQ-007 k_start  input  KW  first frequency word, latched on accepted start.
REQ-008 k_step  input  KW  unsigned increment per dwell, latched on accepted start.
REQ-009 k_stop  input  KW  last permitted frequency word, latched on accepted start.
REQ-010 div  input  DW  sample period in clk cycles, latched on accepted start; 0 treated as 1.
REQ-011 dwell  input  DW  samples per frequency step, latched on accepted start; 0 treated as 1.
REQ-012 loop  input  1  1 = restart from k_start after k_stop; latched on accepted start.
REQ-013 new_sample_ready  input  1  DDS acknowledge, one cycle after each sampling_pulse.
REQ-014 k  output  KW  frequency word to DDS.
REQ-015 sampling_pulse  output  1  one-cycle DDS sample strobe.
REQ-016 busy  output  1  high in RUN.
REQ-017 done  output  1  one-cycle pulse on normal sweep completion.

Function
REQ-018 FSM states SHALL be IDLE, RUN, FINISH; reset state IDLE.
REQ-019 IDLE: start=1 and abort=0 -> RUN next cycle; latch all config; k <= k_start; divider and dwell counters cleared.
REQ-020 RUN: divider counter counts 0..div_eff-1; sampling_pulse=1 for exactly the cycle in which counter equals div_eff-1; first pulse div_eff cycles after entering RUN.
REQ-021 div_eff=1 -> sampling_pulse high every RUN cycle.
REQ-022 Dwell counter increments on each new_sample_ready in RUN; new_sample_ready outside RUN ignored.
REQ-023 On new_sample_ready completing dwell_eff samples: sum = k + k_step computed KW+1 bits wide; if sum <= k_stop (no carry) k <= sum, dwell counter cleared.
REQ-024 Sum carry-out or sum > k_stop: loop=1 -> k <= k_start, stay RUN; loop=0 -> FINISH.
REQ-025 k_step=0 with loop=0: sweep SHALL run until abort (k never exceeds k_stop).
REQ-026 k_start > k_stop: first dwell plays k_start, then end-of-sweep rule of REQ-024 applies.
REQ-027 FINISH: done=1 for one cycle, sampling_pulse=0, k held, -> IDLE next cycle.
REQ-028 abort=1 in RUN or FINISH: -> IDLE next cycle; sampling_pulse forced 0 in the abort cycle; done not asserted; k held.
REQ-029 start while busy or in FINISH SHALL be ignored; start and abort same cycle in IDLE -> stay IDLE.
REQ-030 k changes only on dwell boundaries or accepted start, never in a sampling_pulse cycle of the same dwell.
REQ-031 busy=1 exactly while state is RUN.

Reset
REQ-032 reset=1 SHALL asynchronously force: state IDLE, k=0, sampling_pulse=0, busy=0, done=0, all counters and latched config 0.
REQ-033 Reset asserted mid-sweep SHALL abandon the sweep with no done pulse; operation resumes only on new start after reset release.

Structure
REQ-034 Package dds_pkg SHALL hold KW/DW defaults and the FSM state encoding constants.
REQ-035 Sample strobe generation SHALL be one sub-module, dds_pulse_gen (enable, period, clear -> one-cycle pulse).
REQ-036 All registers SHALL use the same async-reset register style as existing DDS datapath.

Verification
REQ-037 div=4, dwell=2, k_start=100, k_step=50, k_stop=200, loop=0, DDS ack 1 cycle late -> k sequence 100,150,200, six pulses 4 cycles apart, done one cycle after sixth ack, busy low after.
REQ-038 Same config, loop=1 -> k sequence 100,150,200,100,... continuous, no done.
REQ-039 div=0, dwell=0 -> sampling_pulse every RUN cycle, k steps every ack.
REQ-040 k_start=0x3FFFF0, k_step=0x20, k_stop=0x3FFFFF, loop=0 -> carry detected, single dwell at 0x3FFFF0, then done.
REQ-041 abort in cycle 7 of RUN -> IDLE next cycle, no pulse in abort cycle, no done; start re-issued accepted.
REQ-042 reset asserted mid-RUN between clock edges -> outputs 0 immediately; start during busy ignored (config unchanged).
